tod_counter: RTL and testbench

//  Parametrised time-of-day counter: cascaded seconds/minutes/hours in one block, advanced by the
//  1 Hz time-base pulse. Adds time-set handshake, hold, day-rollover pulse and 12h display mode.

---
 rtl/tod_pkg.sv | 22 ++
 rtl/tod_counter_if.sv | 23 ++
 rtl/mod_counter.sv | 42 ++++
 rtl/tod_counter.sv | 130 +++++++++++++
 tb/tb_tod_counter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tod_pkg.sv
// Shared constants, set-field record and 12-hour display mapping for the time-of-day counter.
package tod_pkg;

  localparam int DEF_SEC_MOD  = 60;
  localparam int DEF_MIN_MOD  = 60;
  localparam int DEF_HOUR_MOD = 24;
  localparam int DEF_CNT_W    = 6;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] hour;
    logic [DEF_CNT_W-1:0] min;
    logic [DEF_CNT_W-1:0] sec;
  } set_fields_t;

  // Midnight shows as 12, afternoon hours fold back onto 1..11.
  function automatic int unsigned hours_to_12h(input int unsigned h24);
    if (h24 == 0) return 12;
    if (h24 > 12) return h24 - 12;
    return h24;
  endfunction

endpackage

// File: rtl/tod_counter_if.sv
// Time-set handshake bundle between the controller (master) and the time-of-day counter (slave).
interface tod_counter_if
  import tod_pkg::*;
#(
  parameter int W = DEF_CNT_W
);
  logic         set_valid;
  logic         set_ready;
  logic [W-1:0] set_sec;
  logic [W-1:0] set_min;
  logic [W-1:0] set_hour;
  logic         set_err;

  modport master (
    output set_valid, set_sec, set_min, set_hour,
    input  set_ready, set_err
  );

  modport slave (
    input  set_valid, set_sec, set_min, set_hour,
    output set_ready, set_err
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous load; wrap flags the increment that returns the count to 0.
module mod_counter
  import tod_pkg::*;
#(
  parameter int MOD = DEF_SEC_MOD,
  parameter int W   = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Wrap is combinational so the next stage carries on the same edge.
  assign wrap = inc && !load && (cnt_q == LAST);
  assign q    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tod_counter.sv
// Cascaded seconds/minutes/hours counter with set handshake, hold and 12h display.
// Optional alarm comparator enabled by defining TOD_ALARM_EN.
module tod_counter
  import tod_pkg::*;
#(
  parameter int SEC_MOD  = DEF_SEC_MOD,
  parameter int MIN_MOD  = DEF_MIN_MOD,
  parameter int HOUR_MOD = DEF_HOUR_MOD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tc_time_base,
  input  logic             hold,
  input  logic             mode_12h,
  tod_counter_if.slave     set_if,
  output logic [CNT_W-1:0] q_seconds,
  output logic [CNT_W-1:0] q_minutes,
  output logic [CNT_W-1:0] q_hours,
  output logic [CNT_W-1:0] q_hours_disp,
  output logic             pm,
  output logic             tc_day
`ifdef TOD_ALARM_EN
  ,
  input  logic             alarm_we,
  input  logic [CNT_W-1:0] alarm_min,
  input  logic [CNT_W-1:0] alarm_hour,
  input  logic             alarm_on,
  output logic             alarm_hit
`endif
);

  localparam logic [CNT_W:0] SEC_LIM  = (CNT_W + 1)'(SEC_MOD);
  localparam logic [CNT_W:0] MIN_LIM  = (CNT_W + 1)'(MIN_MOD);
  localparam logic [CNT_W:0] HOUR_LIM = (CNT_W + 1)'(HOUR_MOD);
  localparam bit             HAS_12H  = (HOUR_MOD == 24);

  logic set_ready_q, set_ready_d;
  logic set_err_q, set_err_d;
  logic tc_day_q, tc_day_d;
  logic accept, fields_ok, load, tick_en;
  logic sec_wrap, min_wrap, hour_wrap;

  // A set in the same cycle as a tick always wins, even when it is rejected.
  assign accept    = set_if.set_valid && set_ready_q;
  assign fields_ok = ({1'b0, set_if.set_sec}  < SEC_LIM) &&
                     ({1'b0, set_if.set_min}  < MIN_LIM) &&
                     ({1'b0, set_if.set_hour} < HOUR_LIM);
  assign load      = accept && fields_ok;
  assign tick_en   = tc_time_base && !hold && !accept;

  mod_counter #(.MOD(SEC_MOD), .W(CNT_W)) u_sec (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (tick_en),
    .load     (load),
    .load_val (set_if.set_sec),
    .q        (q_seconds),
    .wrap     (sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(CNT_W)) u_min (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (sec_wrap),
    .load     (load),
    .load_val (set_if.set_min),
    .q        (q_minutes),
    .wrap     (min_wrap)
  );

  mod_counter #(.MOD(HOUR_MOD), .W(CNT_W)) u_hour (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (min_wrap),
    .load     (load),
    .load_val (set_if.set_hour),
    .q        (q_hours),
    .wrap     (hour_wrap)
  );

  always_comb begin
    set_ready_d = !accept;
    set_err_d   = accept && !fields_ok;
    tc_day_d    = hour_wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_ready_q <= 1'b0;
      set_err_q   <= 1'b0;
      tc_day_q    <= 1'b0;
    end else begin
      set_ready_q <= set_ready_d;
      set_err_q   <= set_err_d;
      tc_day_q    <= tc_day_d;
    end
  end

  assign set_if.set_ready = set_ready_q;
  assign set_if.set_err   = set_err_q;
  assign tc_day           = tc_day_q;

  assign pm           = HAS_12H && (32'(q_hours) >= 32'd12);
  assign q_hours_disp = (HAS_12H && mode_12h) ? CNT_W'(hours_to_12h(32'(q_hours))) : q_hours;

`ifdef TOD_ALARM_EN
  logic [CNT_W-1:0] alarm_min_q, alarm_hour_q;
  logic             moved_q;

  // moved_q marks that the counts just changed by tick or set, so a match is a fresh arrival.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_min_q  <= '0;
      alarm_hour_q <= '0;
      moved_q      <= 1'b0;
    end else begin
      if (alarm_we) begin
        alarm_min_q  <= alarm_min;
        alarm_hour_q <= alarm_hour;
      end
      moved_q <= tick_en || load;
    end
  end

  assign alarm_hit = alarm_on && moved_q && (q_hours == alarm_hour_q) &&
                     (q_minutes == alarm_min_q) && (q_seconds == '0);
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Self-checking bench for tod_counter: directed vector table, reset/alarm sequences, random vs model.
// Alarm sequence runs only when TOD_ALARM_EN is defined.
module tb_tod_counter;
  import tod_pkg::*;

  localparam int W       = DEF_CNT_W;
  localparam int DAY_SEC = 24 * 3600;

  typedef struct {
    bit tick;
    bit hold;
    bit mode;
    bit sv;
    int sh;
    int sm;
    int ss;
    int eh;
    int em;
    int es;
    int ed;
    int epm;
    int eday;
    int eerr;
    int erdy;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tick = 1'b0;
  logic         hold = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] qs, qm, qh, qd;
  logic         pm, tday;
`ifdef TOD_ALARM_EN
  logic         alarmWe = 1'b0;
  logic [W-1:0] alarmMin = '0;
  logic [W-1:0] alarmHour = '0;
  logic         alarmOn = 1'b0;
  logic         alarmHit;
`endif

  always #5 clk = ~clk;

  tod_counter_if #(.W(W)) setIf ();

  tod_counter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tc_time_base (tick),
    .hold         (hold),
    .mode_12h     (mode),
    .set_if       (setIf),
    .q_seconds    (qs),
    .q_minutes    (qm),
    .q_hours      (qh),
    .q_hours_disp (qd),
    .pm           (pm),
    .tc_day       (tday)
`ifdef TOD_ALARM_EN
    ,
    .alarm_we     (alarmWe),
    .alarm_min    (alarmMin),
    .alarm_hour   (alarmHour),
    .alarm_on     (alarmOn),
    .alarm_hit    (alarmHit)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned mTotal = 0;
  bit          mReady = 1'b0;
  bit          mErr = 1'b0;
  bit          mDay = 1'b0;
  vec_t        tbl[$];

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mkRow(input bit t, input bit hd, input bit m, input bit sv,
                                 input int sh, input int sm, input int ss,
                                 input int eh, input int em, input int es, input int ed,
                                 input int epm, input int eday, input int eerr, input int erdy);
    vec_t v;
    v = '{t, hd, m, sv, sh, sm, ss, eh, em, es, ed, epm, eday, eerr, erdy};
    return v;
  endfunction

  task automatic driveInputs(input bit t, input bit hd, input bit m, input bit sv,
                             input int sh, input int sm, input int ss);
    tick = t;
    hold = hd;
    mode = m;
    setIf.set_valid = sv;
    setIf.set_hour  = W'(sh);
    setIf.set_min   = W'(sm);
    setIf.set_sec   = W'(ss);
  endtask

  // Compares every output against the reference time-of-day kept as seconds since midnight.
  task automatic checkOutput(input bit m);
    int h, mi, s, d;
    h  = int'(mTotal / 3600);
    mi = int'((mTotal / 60) % 60);
    s  = int'(mTotal % 60);
    d  = m ? ((h % 12 == 0) ? 12 : h % 12) : h;
    checkVal("rnd_seconds", int'(qs), s);
    checkVal("rnd_minutes", int'(qm), mi);
    checkVal("rnd_hours", int'(qh), h);
    checkVal("rnd_disp", int'(qd), d);
    checkVal("rnd_pm", int'(pm), (h >= 12) ? 1 : 0);
    checkVal("rnd_tc_day", int'(tday), int'(mDay));
    checkVal("rnd_set_err", int'(setIf.set_err), int'(mErr));
    checkVal("rnd_set_ready", int'(setIf.set_ready), int'(mReady));
  endtask

  task automatic applyStimulus(input bit t, input bit hd, input bit m, input bit sv,
                               input int sh, input int sm, input int ss);
    bit accept, ok, nDay;
    driveInputs(t, hd, m, sv, sh, sm, ss);
    accept = sv && mReady;
    ok     = (ss < 60) && (sm < 60) && (sh < 24);
    nDay   = 1'b0;
    if (accept) begin
      if (ok) mTotal = int'(sh * 3600 + sm * 60 + ss);
    end else if (t && !hd) begin
      mTotal = (mTotal + 1) % DAY_SEC;
      nDay   = (mTotal == 0);
    end
    @(posedge clk);
    #1;
    mReady = !accept;
    mErr   = accept && !ok;
    mDay   = nDay;
    checkOutput(m);
  endtask

  initial begin
    int sh, sm, ss, r;
    bit t, hd, m, sv;

    driveInputs(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_seconds", int'(qs), 0);
    checkVal("rst_hours", int'(qh), 0);
    checkVal("rst_disp24", int'(qd), 0);
    checkVal("rst_pm", int'(pm), 0);
    checkVal("rst_tc_day", int'(tday), 0);
    checkVal("rst_set_err", int'(setIf.set_err), 0);
    checkVal("rst_set_ready", int'(setIf.set_ready), 0);
    mode = 1'b1;
    #1;
    checkVal("rst_disp12", int'(qd), 12);
    mode = 1'b0;
    reset_n = 1'b1;

    // Directed table: inputs for one cycle, then the outputs expected after that edge.
    tbl.push_back(mkRow(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkRow(1, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkRow(1, 0, 0, 0, 0, 0, 0,    0, 0, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mkRow(1, 0, 0, 0, 0, 0, 0,    0, 0, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mkRow(0, 0, 0, 1, 23, 59, 58, 23, 59, 58, 23, 1, 0, 0, 0));
    tbl.push_back(mkRow(1, 0, 0, 0, 0, 0, 0,    23, 59, 59, 23, 1, 0, 0, 1));
    tbl.push_back(mkRow(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mkRow(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkRow(0, 0, 0, 1, 10, 60, 0,  0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkRow(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkRow(1, 0, 0, 1, 5, 0, 0,    5, 0, 0, 5, 0, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 0, 1, 6, 0, 0,    5, 0, 0, 5, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkRow(1, 1, 0, 0, 0, 0, 0,  5, 0, 0, 5, 0, 0, 0, 1));
    tbl.push_back(mkRow(1, 0, 0, 0, 0, 0, 0,    5, 0, 1, 5, 0, 0, 0, 1));
    tbl.push_back(mkRow(0, 0, 1, 1, 0, 0, 0,    0, 0, 0, 12, 0, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 12, 0, 0, 0, 1));
    tbl.push_back(mkRow(0, 0, 1, 1, 12, 0, 0,   12, 0, 0, 12, 1, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 0, 0, 0, 0,    12, 0, 0, 12, 1, 0, 0, 1));
    tbl.push_back(mkRow(0, 0, 1, 1, 13, 0, 0,   13, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 0, 0, 0, 0,    13, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mkRow(0, 0, 0, 0, 0, 0, 0,    13, 0, 0, 13, 1, 0, 0, 1));
    tbl.push_back(mkRow(0, 0, 0, 1, 24, 0, 0,  13, 0, 0, 13, 1, 0, 1, 0));
    tbl.push_back(mkRow(0, 0, 0, 0, 0, 0, 0,    13, 0, 0, 13, 1, 0, 0, 1));

    foreach (tbl[i]) begin
      driveInputs(tbl[i].tick, tbl[i].hold, tbl[i].mode, tbl[i].sv,
                  tbl[i].sh, tbl[i].sm, tbl[i].ss);
      @(posedge clk);
      #1;
      checkVal($sformatf("row%0d_hours", i), int'(qh), tbl[i].eh);
      checkVal($sformatf("row%0d_minutes", i), int'(qm), tbl[i].em);
      checkVal($sformatf("row%0d_seconds", i), int'(qs), tbl[i].es);
      checkVal($sformatf("row%0d_disp", i), int'(qd), tbl[i].ed);
      checkVal($sformatf("row%0d_pm", i), int'(pm), tbl[i].epm);
      checkVal($sformatf("row%0d_tc_day", i), int'(tday), tbl[i].eday);
      checkVal($sformatf("row%0d_set_err", i), int'(setIf.set_err), tbl[i].eerr);
      checkVal($sformatf("row%0d_set_ready", i), int'(setIf.set_ready), tbl[i].erdy);
    end

    // Reset asserted while a set is being offered: the set must be lost.
    driveInputs(0, 0, 0, 1, 7, 7, 7);
    #3;
    reset_n = 1'b0;
    #1;
    checkVal("midrst_hours", int'(qh), 0);
    checkVal("midrst_set_ready", int'(setIf.set_ready), 0);
    @(posedge clk);
    #1;
    checkVal("midrst_lost_hours", int'(qh), 0);
    checkVal("midrst_lost_seconds", int'(qs), 0);
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    mTotal = 0;
    mReady = 1'b0;
    mErr   = 1'b0;
    mDay   = 1'b0;

    // Random traffic against the seconds-since-midnight model, biased toward day rollover.
    for (int i = 0; i < 3000; i++) begin
      t  = ($urandom_range(0, 1) == 1);
      hd = ($urandom_range(0, 7) == 0);
      m  = ($urandom_range(0, 1) == 1);
      sv = ($urandom_range(0, 9) == 0);
      r  = int'($urandom_range(0, 3));
      if (r == 0) begin
        sh = int'($urandom_range(0, 63));
        sm = int'($urandom_range(0, 63));
        ss = int'($urandom_range(0, 63));
      end else if (r == 1) begin
        sh = 23;
        sm = 59;
        ss = int'($urandom_range(50, 59));
      end else begin
        sh = int'($urandom_range(0, 23));
        sm = int'($urandom_range(0, 59));
        ss = int'($urandom_range(0, 59));
      end
      applyStimulus(t, hd, m, sv, sh, sm, ss);
    end

`ifdef TOD_ALARM_EN
    alarmWe   = 1'b1;
    alarmMin  = W'(30);
    alarmHour = W'(7);
    alarmOn   = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    alarmWe = 1'b0;
    checkVal("alarm_idle", int'(alarmHit), 0);
    applyStimulus(0, 0, 0, 1, 7, 29, 59);
    checkVal("alarm_before", int'(alarmHit), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkVal("alarm_hit", int'(alarmHit), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkVal("alarm_pulse_end", int'(alarmHit), 0);
    applyStimulus(0, 0, 0, 1, 7, 29, 59);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkVal("alarm_hit_again", int'(alarmHit), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkVal("alarm_reset", int'(alarmHit), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
